// File: rtl/icm_ltc_sync_ctrl.sv
// ============================================================================
// Module   : icm_ltc_sync_ctrl
// Purpose  : ICM LTC deserializer sequencer; owns the local 48-bit LTC counter.
//            Optional macro ICM_LTC_MISMATCH_RELOAD_EN: reload ltc on LOCKED miss.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module icm_ltc_sync_ctrl #(
  parameter int          QUAL_CNT    = 32,
  parameter logic [47:0] LAT_ADJ     = 48'd0,
  parameter int          MSG_TIMEOUT = 2000000,
  parameter int          RESYNC_CNT  = 4000,
  parameter int          MAX_MISS    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [47:0] des_ltc,
  input  logic        des_valid,
  output logic        des_en,
  output logic [47:0] ltc,
  output logic        ltc_valid,
  output logic        locked,
  output logic [15:0] miss_cnt,
  output logic        timeout
);

  localparam int QW = $clog2(QUAL_CNT + 1);
  localparam int TW = $clog2(MSG_TIMEOUT + 1);
  localparam int RW = $clog2(RESYNC_CNT + 1);
  localparam int MW = $clog2(MAX_MISS + 1);

  localparam logic [QW-1:0] QUAL_LAST = QW'(QUAL_CNT - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(MSG_TIMEOUT - 1);
  localparam logic [RW-1:0] RS_LAST   = RW'(RESYNC_CNT - 1);
  localparam logic [MW-1:0] MISS_LIM  = MW'(MAX_MISS);
  localparam logic [47:0]   LOAD_ADJ  = LAT_ADJ + 48'(QUAL_CNT);

`ifdef ICM_LTC_MISMATCH_RELOAD_EN
  localparam logic RELOAD_EN = 1'b1;
`else
  localparam logic RELOAD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARM      = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_RESYNC   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [47:0]   prev_ltc_q;
  logic          prev_vld_q;
  logic          qual_act_q;
  logic [QW-1:0] qual_q, qual_d;
  logic [47:0]   last_acc_q, last_acc_d;
  logic          last_vld_q, last_vld_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [RW-1:0] rs_cnt_q, rs_cnt_d;
  logic [MW-1:0] consec_q, consec_d;
  logic [15:0]   miss_q, miss_d;
  logic          timeout_q, timeout_d;
  logic [47:0]   ltc_q, ltc_d;
  logic          ltc_vld_q, ltc_vld_d;
  logic          des_en_q;

  logic          w_active;
  logic          w_stable;
  logic [QW-1:0] w_qual;
  logic          w_accept;
  logic [47:0]   w_load;
  logic          w_match;
  logic          w_miss_lim;

  // The qualifier only counts cycles that follow an active cycle, so a word
  // already on the bus when ARM is entered starts qualifying from zero.
  always_comb begin
    w_active = en && ((state_q == ST_ARM) || (state_q == ST_LOCKED));
    w_stable = des_valid && prev_vld_q && qual_act_q && (des_ltc == prev_ltc_q);
    if (!w_stable) begin
      w_qual = '0;
    end else if (qual_q == QUAL_LAST) begin
      w_qual = qual_q;
    end else begin
      w_qual = qual_q + QW'(1);
    end
    w_accept   = w_active && des_valid && (w_qual == QUAL_LAST) &&
                 (!last_vld_q || (des_ltc != last_acc_q));
    w_load     = des_ltc + LOAD_ADJ;
    w_match    = (w_load == (ltc_q + 48'd1));
    w_miss_lim = ((consec_q + MW'(1)) >= MISS_LIM);
  end

  always_comb begin
    state_d    = state_q;
    qual_d     = w_active ? w_qual : '0;
    last_acc_d = last_acc_q;
    last_vld_d = last_vld_q;
    to_cnt_d   = to_cnt_q;
    rs_cnt_d   = '0;
    consec_d   = consec_q;
    miss_d     = miss_q;
    timeout_d  = timeout_q;
    ltc_d      = ltc_vld_q ? (ltc_q + 48'd1) : ltc_q;
    ltc_vld_d  = ltc_vld_q;

    if (w_accept) begin
      last_acc_d = des_ltc;
      last_vld_d = 1'b1;
    end

    if (!en) begin
      state_d    = ST_DISABLED;
      to_cnt_d   = '0;
      consec_d   = '0;
      miss_d     = '0;
      timeout_d  = 1'b0;
      last_vld_d = 1'b0;
    end else begin
      case (state_q)
        ST_DISABLED: begin
          state_d  = ST_ARM;
          to_cnt_d = '0;
        end
        ST_ARM: begin
          if (w_accept) begin
            ltc_d     = w_load;
            ltc_vld_d = 1'b1;
            state_d   = ST_LOCKED;
            to_cnt_d  = '0;
          end else if (to_cnt_q == TO_LAST) begin
            timeout_d = 1'b1;
            state_d   = ST_RESYNC;
            to_cnt_d  = '0;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end
        ST_LOCKED: begin
          if (w_accept) begin
            to_cnt_d = '0;
            if (w_match) begin
              consec_d = '0;
            end else begin
              if (miss_q != 16'hFFFF) begin
                miss_d = miss_q + 16'd1;
              end
              consec_d = consec_q + MW'(1);
              if (RELOAD_EN) begin
                ltc_d = w_load;
              end
              if (w_miss_lim) begin
                state_d = ST_RESYNC;
              end
            end
          end else if (to_cnt_q == TO_LAST) begin
            timeout_d = 1'b1;
            state_d   = ST_RESYNC;
            to_cnt_d  = '0;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end
        ST_RESYNC: begin
          if (rs_cnt_q == RS_LAST) begin
            state_d  = ST_ARM;
            consec_d = '0;
          end else begin
            rs_cnt_d = rs_cnt_q + RW'(1);
          end
        end
        default: state_d = ST_DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_DISABLED;
      prev_ltc_q <= '0;
      prev_vld_q <= 1'b0;
      qual_act_q <= 1'b0;
      qual_q     <= '0;
      last_acc_q <= '0;
      last_vld_q <= 1'b0;
      to_cnt_q   <= '0;
      rs_cnt_q   <= '0;
      consec_q   <= '0;
      miss_q     <= '0;
      timeout_q  <= 1'b0;
      ltc_q      <= '0;
      ltc_vld_q  <= 1'b0;
      des_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_ltc_q <= des_ltc;
      prev_vld_q <= des_valid;
      qual_act_q <= w_active;
      qual_q     <= qual_d;
      last_acc_q <= last_acc_d;
      last_vld_q <= last_vld_d;
      to_cnt_q   <= to_cnt_d;
      rs_cnt_q   <= rs_cnt_d;
      consec_q   <= consec_d;
      miss_q     <= miss_d;
      timeout_q  <= timeout_d;
      ltc_q      <= ltc_d;
      ltc_vld_q  <= ltc_vld_d;
      des_en_q   <= w_active;
    end
  end

  assign des_en    = des_en_q;
  assign ltc       = ltc_q;
  assign ltc_valid = ltc_vld_q;
  assign locked    = (state_q == ST_LOCKED);
  assign miss_cnt  = miss_q;
  assign timeout   = timeout_q;

endmodule

`default_nettype wire
